// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Memory-stage data-access sequencer. Turns each load/store into
//               one request/acknowledge transaction on the data-memory bus,
//               stalls the pipeline until it completes, aligns store lanes,
//               extends load data and reports misalignment and bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  be_op,
    input  logic [2:0]  me_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_buserr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int              c_CW      = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_ld_op;
    logic [1:0]      r_sel;

    logic        w_idle;
    logic        w_wr;
    logic        w_rd;
    logic        w_st_mis;
    logic        w_ld_half;
    logic        w_ld_word;
    logic        w_ld_mis;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    // Access decode; a store wins when both qualifiers are present
    assign w_idle    = (r_state == S_IDLE);
    assign w_wr      = mem_write & (be_op != 2'b00);
    assign w_rd      = mem_read & (me_op != 3'b000) & ~w_wr;
    assign w_st_mis  = ((be_op == 2'b10) & addr[0]) |
                       ((be_op == 2'b11) & (addr[1:0] != 2'b00));
    assign w_ld_half = (me_op == 3'b011) | (me_op == 3'b100);
    assign w_ld_word = me_op[2] & (me_op[1] | me_op[0]);
    assign w_ld_mis  = (w_ld_half & addr[0]) |
                       (w_ld_word & (addr[1:0] != 2'b00));
    assign w_start   = w_idle & ~flush &
                       ((w_wr & ~w_st_mis) | (w_rd & ~w_ld_mis));

    assign exc_ades  = ~reset & w_idle & w_wr & w_st_mis;
    assign exc_adel  = ~reset & w_idle & w_rd & w_ld_mis;
    assign stall     = ~reset & (w_start | (r_state == S_WAIT));

    // Store lane placement: replicate the source so every enabled lane is right
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata;
        case (be_op)
            2'b01: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b10: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = wdata;
            end
        endcase
    end

    // Load extraction from the latched lane offset and load type
    always_comb begin
        case (r_sel)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_sel[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_ld_op)
            3'b001:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_ld_data = {24'd0, w_byte};
            3'b011:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = bus_rdata;
        endcase
    end

    // Transaction sequencer: IDLE -> WAIT (until ack or timeout) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ld_op     <= 3'b000;
            r_sel       <= 2'b00;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            exc_buserr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    rdata_valid <= 1'b0;
                    exc_buserr  <= 1'b0;
                    if (w_start) begin
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_we    <= w_wr;
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                        r_ld_op   <= me_op;
                        r_sel     <= addr[1:0];
                        bus_req   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata       <= w_ld_data;
                            rdata_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == c_CNT_MAX) begin
                        bus_req    <= 1'b0;
                        exc_buserr <= 1'b1;
                        rdata      <= 32'd0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    rdata_valid <= 1'b0;
                    exc_buserr  <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
